// File: rtl/calc_seq_ctrl.sv
// Operation sequencer for the 3-bit calculator datapath: operand capture, add/sub via shared datapath,
// multi-cycle multiply by repeated addition (built only when CALC_MUL_EN is defined), optional auto-clear.
module calc_seq_ctrl #(
    parameter int W        = 3,
    parameter int AUTO_CLR = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   sw_val,
    input  logic           btn_load,
    input  logic           start,
    input  logic           clear,
    input  logic [1:0]     op_code,
    output logic [W-1:0]   dp_A,
    output logic [W-1:0]   dp_B,
    output logic           dp_sel,
    input  logic [W:0]     dp_sum4,
    input  logic [W:0]     dp_diff4,
    output logic [2*W-1:0] result,
    output logic           neg,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2:0]     state_dbg
);

    localparam int RW  = 2 * W;
    localparam int ACW = (AUTO_CLR > 1) ? $clog2(AUTO_CLR + 1) : 1;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB_AB = 2'b01;
    localparam logic [1:0] OP_SUB_BA = 2'b10;
    localparam logic [1:0] OP_MUL    = 2'b11;

    typedef enum logic [2:0] {
        IDLE_A = 3'd0,
        WAIT_B = 3'd1,
        READY  = 3'd2,
        EXEC   = 3'd3,
        MUL    = 3'd4,
        SHOW   = 3'd5
    } state_t;

    // Magnitude of a negative two's-complement value held in W bits.
    function automatic logic [W-1:0] neg_mag(input logic [W-1:0] s);
        neg_mag = ~s + W'(1);
    endfunction

    state_t          state_r, state_nxt;
    logic [W-1:0]    opa_r, opa_nxt;
    logic [W-1:0]    opb_r, opb_nxt;
    logic [1:0]      op_r, op_nxt;
    logic            sel_r, sel_nxt;
    logic [RW-1:0]   result_r, result_nxt;
    logic            neg_r, neg_nxt;
    logic            busy_r, busy_nxt;
    logic            done_r, done_nxt;
    logic            err_r, err_nxt;
    logic [ACW-1:0]  ac_cnt_r, ac_cnt_nxt;
    logic            auto_clr_s;
    logic [W-1:0]    minuend_s;
    logic [W-1:0]    subtr_s;
`ifdef CALC_MUL_EN
    logic [RW-1:0]   acc_r, acc_nxt;
    logic [W-1:0]    cnt_r, cnt_nxt;
    logic [RW-1:0]   mul_sum_s;
`endif

    // Next-state and next-register computation for the sequencer.
    always_comb begin
        state_nxt  = state_r;
        opa_nxt    = opa_r;
        opb_nxt    = opb_r;
        op_nxt     = op_r;
        sel_nxt    = sel_r;
        result_nxt = result_r;
        neg_nxt    = neg_r;
        err_nxt    = err_r;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        ac_cnt_nxt = '0;
        auto_clr_s = (AUTO_CLR != 0) && (state_r == SHOW) && (ac_cnt_r == ACW'(AUTO_CLR - 1));
        minuend_s  = (op_r == OP_SUB_BA) ? opb_r : opa_r;
        subtr_s    = (op_r == OP_SUB_BA) ? opa_r : opb_r;
`ifdef CALC_MUL_EN
        acc_nxt    = acc_r;
        cnt_nxt    = cnt_r;
        mul_sum_s  = acc_r + {{W{1'b0}}, opa_r};
`endif

        if (clear || auto_clr_s) begin
            state_nxt  = IDLE_A;
            result_nxt = '0;
            neg_nxt    = 1'b0;
            err_nxt    = 1'b0;
`ifdef CALC_MUL_EN
            acc_nxt    = '0;
            cnt_nxt    = '0;
`endif
        end else begin
            case (state_r)
                IDLE_A: begin
                    if (btn_load) begin
                        opa_nxt   = sw_val;
                        state_nxt = WAIT_B;
                    end else begin
                        state_nxt = IDLE_A;
                    end
                end
                WAIT_B: begin
                    if (btn_load) begin
                        opb_nxt   = sw_val;
                        state_nxt = READY;
                    end else begin
                        state_nxt = WAIT_B;
                    end
                end
                READY: begin
                    if (start) begin
                        op_nxt    = op_code;
                        sel_nxt   = (op_code == OP_SUB_BA);
                        err_nxt   = 1'b0;
                        busy_nxt  = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = READY;
                    end
                end
                EXEC: begin
                    state_nxt = SHOW;
                    done_nxt  = 1'b1;
                    case (op_r)
                        OP_ADD: begin
                            result_nxt = {{(RW-W-1){1'b0}}, dp_sum4};
                            neg_nxt    = 1'b0;
                        end
                        OP_SUB_AB, OP_SUB_BA: begin
                            // sub3_c2 reports x-0 as negative, so a zero subtrahend bypasses it.
                            if (subtr_s == '0) begin
                                result_nxt = {{(RW-W){1'b0}}, minuend_s};
                                neg_nxt    = 1'b0;
                            end else if (dp_diff4[W]) begin
                                result_nxt = {{(RW-W){1'b0}}, neg_mag(dp_diff4[W-1:0])};
                                neg_nxt    = 1'b1;
                            end else begin
                                result_nxt = {{(RW-W){1'b0}}, dp_diff4[W-1:0]};
                                neg_nxt    = 1'b0;
                            end
                        end
                        OP_MUL: begin
                            result_nxt = '0;
                            neg_nxt    = 1'b0;
`ifdef CALC_MUL_EN
                            acc_nxt = '0;
                            cnt_nxt = opb_r;
                            if (opb_r != '0) begin
                                state_nxt = MUL;
                                done_nxt  = 1'b0;
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = SHOW;
                            end
`else
                            err_nxt = 1'b1;
`endif
                        end
                        default: begin
                            result_nxt = '0;
                            neg_nxt    = 1'b0;
                        end
                    endcase
                end
`ifdef CALC_MUL_EN
                MUL: begin
                    acc_nxt = mul_sum_s;
                    cnt_nxt = cnt_r - W'(1);
                    neg_nxt = 1'b0;
                    if (cnt_r == W'(1)) begin
                        result_nxt = mul_sum_s;
                        done_nxt   = 1'b1;
                        state_nxt  = SHOW;
                    end else begin
                        busy_nxt  = 1'b1;
                        state_nxt = MUL;
                    end
                end
`endif
                SHOW: begin
                    ac_cnt_nxt = ac_cnt_r + ACW'(1);
                    if (btn_load) begin
                        opa_nxt    = sw_val;
                        ac_cnt_nxt = '0;
                        state_nxt  = WAIT_B;
                    end else begin
                        state_nxt = SHOW;
                    end
                end
                default: begin
                    state_nxt = IDLE_A;
                end
            endcase
        end
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE_A;
            opa_r    <= '0;
            opb_r    <= '0;
            op_r     <= 2'b00;
            sel_r    <= 1'b0;
            result_r <= '0;
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            ac_cnt_r <= '0;
`ifdef CALC_MUL_EN
            acc_r    <= '0;
            cnt_r    <= '0;
`endif
        end else begin
            state_r  <= state_nxt;
            opa_r    <= opa_nxt;
            opb_r    <= opb_nxt;
            op_r     <= op_nxt;
            sel_r    <= sel_nxt;
            result_r <= result_nxt;
            neg_r    <= neg_nxt;
            busy_r   <= busy_nxt;
            done_r   <= done_nxt;
            err_r    <= err_nxt;
            ac_cnt_r <= ac_cnt_nxt;
`ifdef CALC_MUL_EN
            acc_r    <= acc_nxt;
            cnt_r    <= cnt_nxt;
`endif
        end
    end

    assign dp_A      = opa_r;
    assign dp_B      = opb_r;
    assign dp_sel    = sel_r;
    assign result    = result_r;
    assign neg       = neg_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign state_dbg = state_r;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: directed steps plus random operations against an arithmetic model.
module tb_calc_seq_ctrl;

`ifdef CALC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sw_val;
    logic       btn_load, start, clear;
    logic [1:0] op_code;

    logic [2:0] u0_dp_A, u0_dp_B, u1_dp_A, u1_dp_B;
    logic       u0_dp_sel, u1_dp_sel;
    logic [3:0] u0_sum4, u0_diff4, u1_sum4, u1_diff4;
    logic [5:0] u0_result, u1_result;
    logic       u0_neg, u0_busy, u0_done, u0_err;
    logic       u1_neg, u1_busy, u1_done, u1_err;
    logic [2:0] u0_state, u1_state;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Behaviour of sub3_c2, including its habit of flagging x-0 as negative.
    function automatic logic [3:0] sub_model(input logic [2:0] a, input logic [2:0] b, input logic sel);
        logic [2:0] m, s, d;
        m = sel ? b : a;
        s = sel ? a : b;
        d = m - s;
        return {(m < s) || (s == 3'd0), d};
    endfunction

    assign u0_sum4  = {1'b0, u0_dp_A} + {1'b0, u0_dp_B};
    assign u0_diff4 = sub_model(u0_dp_A, u0_dp_B, u0_dp_sel);
    assign u1_sum4  = {1'b0, u1_dp_A} + {1'b0, u1_dp_B};
    assign u1_diff4 = sub_model(u1_dp_A, u1_dp_B, u1_dp_sel);

    calc_seq_ctrl #(.W(3), .AUTO_CLR(0)) u0 (
        .clk(clk), .rst_n(rst_n), .sw_val(sw_val), .btn_load(btn_load), .start(start),
        .clear(clear), .op_code(op_code), .dp_A(u0_dp_A), .dp_B(u0_dp_B), .dp_sel(u0_dp_sel),
        .dp_sum4(u0_sum4), .dp_diff4(u0_diff4), .result(u0_result), .neg(u0_neg),
        .busy(u0_busy), .done(u0_done), .err(u0_err), .state_dbg(u0_state)
    );

    calc_seq_ctrl #(.W(3), .AUTO_CLR(4)) u1 (
        .clk(clk), .rst_n(rst_n), .sw_val(sw_val), .btn_load(btn_load), .start(start),
        .clear(clear), .op_code(op_code), .dp_A(u1_dp_A), .dp_B(u1_dp_B), .dp_sel(u1_dp_sel),
        .dp_sum4(u1_sum4), .dp_diff4(u1_diff4), .result(u1_result), .neg(u1_neg),
        .busy(u1_busy), .done(u1_done), .err(u1_err), .state_dbg(u1_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Arithmetic reference: result, sign, error flag and start-to-done latency.
    task automatic model(input int a, input int b, input int op,
                         output int res, output int ng, output int er, output int lat);
        int d;
        res = 0; ng = 0; er = 0; lat = 2; d = 0;
        case (op)
            0: res = a + b;
            1: d = a - b;
            2: d = b - a;
            default: begin
                if (MUL_EN) begin
                    res = a * b;
                    lat = 2 + b;
                end else begin
                    er = 1;
                end
            end
        endcase
        if (op == 1 || op == 2) begin
            ng  = (d < 0) ? 1 : 0;
            res = (d < 0) ? -d : d;
        end
    endtask

    task automatic pulse_load(input logic [2:0] v);
        sw_val = v; btn_load = 1'b1;
        @(negedge clk);
        btn_load = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] op);
        op_code = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
        int res, ng, er, lat, k, bc;
        model(int'(a), int'(b), int'(op), res, ng, er, lat);
        do_clear();
        chk("clr_state", u0_state, 0);
        chk("clr_err", u0_err, 0);
        pulse_load(a);
        pulse_load(b);
        chk("ready_state", u0_state, 2);
        pulse_start(op);
        chk("exec_sel", u0_dp_sel, (op == 2'b10) ? 1 : 0);
        k = 1; bc = 0;
        while (u0_done !== 1'b1 && k < 40) begin
            if (u0_busy === 1'b1) bc++;
            @(negedge clk);
            k++;
        end
        chk("latency", k, lat);
        chk("busy_cycles", bc, lat - 1);
        chk("result", u0_result, res);
        chk("neg", u0_neg, ng);
        chk("err", u0_err, er);
        chk("busy_at_done", u0_busy, 0);
        chk("ac_result", u1_result, res);
        @(negedge clk);
        chk("done_pulse", u0_done, 0);
        repeat (3) @(negedge clk);
        chk("ac_state", u1_state, 0);
        chk("ac_clr_result", u1_result, 0);
        chk("show_held", u0_state, 5);
        chk("result_held", u0_result, res);
    endtask

    initial begin
        int res, ng, er, lat;
        logic saw_done;
        rst_n = 1'b0; sw_val = 3'd0; btn_load = 1'b0; start = 1'b0; clear = 1'b0; op_code = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_state", u0_state, 0);
        chk("rst_result", u0_result, 0);
        chk("rst_neg", u0_neg, 0);
        chk("rst_busy", u0_busy, 0);
        chk("rst_done", u0_done, 0);
        chk("rst_err", u0_err, 0);
        chk("rst_dpA", u0_dp_A, 0);
        chk("rst_dpB", u0_dp_B, 0);
        chk("rst_sel", u0_dp_sel, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd5, 3'd6, 2'b00);
        run_op(3'd2, 3'd5, 2'b01);
        run_op(3'd2, 3'd5, 2'b10);
        run_op(3'd4, 3'd0, 2'b01);
        run_op(3'd0, 3'd0, 2'b10);
        run_op(3'd7, 3'd0, 2'b10);
        run_op(3'd0, 3'd7, 2'b01);
        run_op(3'd7, 3'd7, 2'b11);
        run_op(3'd3, 3'd0, 2'b11);

        // u0 sits in SHOW after the last op: start ignored, btn_load reloads A.
        model(3, 0, 3, res, ng, er, lat);
        pulse_start(2'b00);
        chk("show_start_state", u0_state, 5);
        chk("show_start_done", u0_done, 0);
        pulse_load(3'd6);
        chk("show_load_state", u0_state, 1);
        chk("show_load_dpA", u0_dp_A, 6);
        chk("show_load_keep", u0_result, res);
        pulse_load(3'd1);
        pulse_load(3'd4);
        chk("ready_load_state", u0_state, 2);
        chk("ready_load_dpB", u0_dp_B, 1);
        chk("err_held", u0_err, er);
        pulse_start(2'b00);
        chk("start_err_clr", u0_err, 0);
        chk("start_exec", u0_state, 3);
        @(negedge clk);
        chk("reload_result", u0_result, 7);

        do_clear();
        pulse_start(2'b01);
        chk("idle_start_state", u0_state, 0);
        chk("idle_start_busy", u0_busy, 0);

`ifdef CALC_MUL_EN
        do_clear();
        pulse_load(3'd7);
        pulse_load(3'd7);
        pulse_start(2'b11);
        repeat (3) @(negedge clk);
        chk("mid_mul_busy", u0_busy, 1);
        sw_val = 3'd2; clear = 1'b1; btn_load = 1'b1;
        @(negedge clk);
        clear = 1'b0; btn_load = 1'b0;
        chk("mclr_state", u0_state, 0);
        chk("mclr_result", u0_result, 0);
        chk("mclr_busy", u0_busy, 0);
        chk("mclr_dpA", u0_dp_A, 7);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (u0_done === 1'b1) saw_done = 1'b1;
        end
        chk("mclr_no_done", saw_done, 0);

        pulse_load(3'd7);
        pulse_load(3'd7);
        pulse_start(2'b11);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_state", u0_state, 0);
        chk("mrst_result", u0_result, 0);
        chk("mrst_busy", u0_busy, 0);
        chk("mrst_dpA", u0_dp_A, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (u0_done === 1'b1) saw_done = 1'b1;
        end
        chk("mrst_no_done", saw_done, 0);
`endif

        for (int i = 0; i < 25; i++) begin
            run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Operation sequencer for the 3-bit calculator datapath. It captures operands A and B from switches on one-cycle button pulses and latches an op code on start. It drives the shared adder3/sub3_c2 operand and select lines, then registers a 6-bit unsigned magnitude plus sign flag for the display. It also owns the multi-cycle multiply, done by repeated addition into an internal accumulator.

Parameters:
W, 3, operand width; the datapath supports only 3, so other values are unsupported.
AUTO_CLR, 0, cycles spent in SHOW before auto-return to IDLE_A; 0 disables auto-return.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sw_val  in  3  operand switches
btn_load  in  1  one-cycle pulse (already debounced): capture sw_val
start  in  1  one-cycle pulse: latch op_code and execute
clear  in  1  one-cycle pulse: abort/clear to IDLE_A
op_code  in  2  00 add, 01 A-B, 10 B-A, 11 mul
dp_A  out  3  to adder3.A and sub3_c2.A (= opA register)
dp_B  out  3  to adder3.B and sub3_c2.B (= opB register)
dp_sel  out  1  to sub3_c2.sel (registered op==10)
dp_sum4  in  4  adder3.SUM4
dp_diff4  in  4  sub3_c2.DIFF4 {sign, S[2:0]}
result  out  6  unsigned magnitude
neg  out  1  result is negative
busy  out  1  high in EXEC/MUL
done  out  1  one-cycle pulse on entry to SHOW
err  out  1  unsupported op executed
state_dbg  out  3  current state code

Behaviour:
- Reset (async, rst_n=0): state IDLE_A; opA, opB, op, result, acc, cnt and auto-clear counter = 0; neg, busy, done, err, dp_sel = 0.
- State codes: IDLE_A=0, WAIT_B=1, READY=2, EXEC=3, MUL=4, SHOW=5.
- IDLE_A: btn_load -> opA<=sw_val, go WAIT_B.
- WAIT_B: btn_load -> opB<=sw_val, go READY.
- READY: start -> op<=op_code, err<=0, go EXEC. btn_load is ignored.
- EXEC, add/sub (one cycle): sample the datapath at end of cycle, write result/neg, go SHOW.
- EXEC, mul: acc<=0, cnt<=opB; if opB==0 go SHOW (result 0), else go MUL.
- MUL: each cycle acc<=acc+opA, cnt<=cnt-1; when cnt==1 write result<=acc+opA and go SHOW. Max 7*7=49 fits 6 bits.
- SHOW: result/neg held. btn_load -> opA<=sw_val, go WAIT_B; result is kept until the next write. start is ignored.
- Latency from start pulse at cycle t:
  - add/sub: done and result valid at t+2.
  - mul: done and result valid at t+2+opB.
- Add: result={2'b00,dp_sum4}, neg=0 (max 14).
- Sub: dp_diff4[3]=1 means negative, and S[2:0] is then a 3-bit two's-complement value. The controller converts it: magnitude = (~S+1)[2:0] when negative, else S.
- Sub, zero subtrahend: sub3_c2 flags x-0 as negative (carry is 0). When the subtrahend (opB for 01, opA for 10) is 0, the controller ignores dp_diff4 and sets result=minuend, neg=0. 0-0 gives 0 with neg=0.
- dp_sel is valid from EXEC entry; dp_A/dp_B are continuous copies of the operand registers.
- clear: from any state, go IDLE_A; result, neg, err, busy, acc, cnt = 0; no done. clear beats btn_load/start in the same cycle.
- start outside READY and btn_load in READY/EXEC/MUL are ignored.
- AUTO_CLR>0: a counter counts cycles in SHOW. At count AUTO_CLR it behaves as clear. A btn_load in SHOW resets the counter.
- rst_n asserted mid-MUL: immediate abort, all reset values, no done.

Optional Feature:
CALC_MUL_EN.
- Defined: op 11 runs the multiply (EXEC/MUL path); err is never set.
- Undefined: MUL state and accumulator are not built. op 11 goes EXEC -> SHOW in one cycle with result=0, neg=0, err=1, done pulsed. err clears on the next start or clear.

Test Plan:
- Load A=5, B=6, op 00, start -> done at t+2, result=11, neg=0, busy high one cycle.
- A=2, B=5, op 01 -> result=3, neg=1; same operands, op 10 -> result=3, neg=0.
- A=4, B=0, op 01 -> result=4, neg=0 (zero-subtrahend override); A=0, B=0, op 10 -> result=0, neg=0.
- With CALC_MUL_EN: A=7, B=7, op 11 -> busy for 8 cycles, done at t+9, result=49. B=0 -> done at t+2, result=0. Without the macro: op 11 -> result=0, err=1.
- clear asserted in MUL after 3 iterations, together with btn_load -> state_dbg=0, result=0, no done pulse. Repeat using rst_n=0 mid-MUL.
- AUTO_CLR=4: after done, idle 4 cycles -> state_dbg=0, result=0. start in IDLE_A and btn_load in READY cause no state change.
